// File: rtl/jt1943_main_glue.sv
// jt1943_main_glue: glue logic around the 1943 main Z80.
// Covers address decode, control registers, the cabinet input and data-in
// multiplexers, banked ROM address, VBL interrupt, wait states and the
// protection device.
// Optional build macro CHEAT_INVINCIBLE_EN: when defined, a RAM read at
// F206/F286 returns 40 while cheat_invincible is high.
module jt1943_main_glue (
    input  logic        clk,
    input  logic        t80_rst_n,
    input  logic        cen6,
    input  logic [15:0] A,
    input  logic        mreq_n,
    input  logic        rfsh_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        iorq_n,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        wait_n,
    output logic        int_n,
    input  logic [8:0]  V,
    input  logic        LVBL,
    input  logic [7:0]  char_dout,
    input  logic [7:0]  ram_dout,
    input  logic [7:0]  rom_data,
    input  logic        char_wait,
    input  logic        rom_ok,
    input  logic [6:0]  joystick1,
    input  logic [6:0]  joystick2,
    input  logic [1:0]  start_button,
    input  logic [1:0]  coin_input,
    input  logic [7:0]  dipsw_a,
    input  logic [7:0]  dipsw_b,
    input  logic        cheat_invincible,
    output logic        rom_cs,
    output logic        ram_cs,
    output logic        char_cs,
    output logic        snd_latch_cs,
    output logic        OKOUT,
    output logic [1:0]  scr1posh_cs,
    output logic [1:0]  scr2posh_cs,
    output logic [17:0] rom_addr,
    output logic [7:0]  scrposv,
    output logic        CHON,
    output logic        SC1ON,
    output logic        SC2ON,
    output logic        OBJON,
    output logic        flip,
    output logic        sres_b,
    output logic        coin_cnt
);

    logic       in_cs, bank_cs, secwr_cs, scrposv_cs, gfxen_cs;
    logic [2:0] bank;
    logic [7:0] prot, sec_out, cab_in, ram_data;
    logic       int_rqb, int_rqb_last, irq_ack;
    logic       mw0, mw1, rom_cs_last;
    logic       unused_sig;

`ifdef CHEAT_INVINCIBLE_EN
    assign ram_data   = (cheat_invincible && (A == 16'hF206 || A == 16'hF286)) ? 8'h40 : ram_dout;
    assign unused_sig = ^{V[8], V[4:0], rd_n};
`else
    assign ram_data   = ram_dout;
    assign unused_sig = ^{V[8], V[4:0], rd_n, cheat_invincible};
`endif

    // Memory map decode; refresh cycles never select anything
    always_comb begin
        rom_cs = 1'b0; ram_cs = 1'b0; char_cs = 1'b0; in_cs = 1'b0;
        snd_latch_cs = 1'b0; bank_cs = 1'b0; OKOUT = 1'b0; secwr_cs = 1'b0;
        scr1posh_cs = 2'b00; scr2posh_cs = 2'b00; scrposv_cs = 1'b0; gfxen_cs = 1'b0;
        if (rfsh_n && !mreq_n) begin
            case (A[15:13])
                3'b110: begin
                    case (A[12:11])
                        2'b00: in_cs = 1'b1;
                        2'b01: begin
                            case (A[2:0])
                                3'd0: snd_latch_cs = 1'b1;
                                3'd4: bank_cs      = 1'b1;
                                3'd6: OKOUT        = 1'b1;
                                3'd7: secwr_cs     = 1'b1;
                                default: ;
                            endcase
                        end
                        2'b10: char_cs = 1'b1;
                        default: begin
                            if (!A[3] && !wr_n) begin
                                case (A[2:0])
                                    3'd0: scr1posh_cs = 2'b01;
                                    3'd1: scr1posh_cs = 2'b10;
                                    3'd2: scrposv_cs  = 1'b1;
                                    3'd3: scr2posh_cs = 2'b01;
                                    3'd4: scr2posh_cs = 2'b10;
                                    3'd6: gfxen_cs    = 1'b1;
                                    default: ;
                                endcase
                            end
                        end
                    endcase
                end
                3'b111:  ram_cs = 1'b1;
                default: rom_cs = 1'b1;
            endcase
        end
    end

    // Video/sound control registers and the protection latch
    always_ff @(posedge clk or negedge t80_rst_n) begin
        if (!t80_rst_n) begin
            CHON <= 1'b0; flip <= 1'b0; sres_b <= 1'b1; bank <= 3'd0; coin_cnt <= 1'b0;
            scrposv <= 8'd0; OBJON <= 1'b0; SC2ON <= 1'b0; SC1ON <= 1'b0; prot <= 8'd0;
        end else if (cen6) begin
            if (bank_cs && !wr_n) begin
                CHON     <= cpu_dout[7];
                flip     <= cpu_dout[6];
                sres_b   <= ~cpu_dout[5];
                bank     <= cpu_dout[4:2];
                coin_cnt <= cpu_dout[1] | cpu_dout[0];
            end
            if (scrposv_cs) scrposv <= cpu_dout;
            if (gfxen_cs) {OBJON, SC2ON, SC1ON} <= cpu_dout[6:4];
            if (secwr_cs && !wr_n) prot <= cpu_dout;
        end
    end

    // Protection device answer table
    always_comb begin
        case (prot)
            8'h24:   sec_out = 8'h1D;
            8'h60:   sec_out = 8'hF7;
            8'h01:   sec_out = 8'hAC;
            8'h55:   sec_out = 8'h50;
            8'h56:   sec_out = 8'hE2;
            8'h97:   sec_out = 8'h5D;
            default: sec_out = 8'h00;
        endcase
    end

    // Cabinet inputs, all active-low
    always_comb begin
        case (A[2:0])
            3'd0:    cab_in = {coin_input, 2'b11, ~LVBL, 1'b1, start_button};
            3'd1:    cab_in = {1'b1, joystick1};
            3'd2:    cab_in = {1'b1, joystick2};
            3'd3:    cab_in = dipsw_a;
            3'd4:    cab_in = dipsw_b;
            3'd7:    cab_in = sec_out;
            default: cab_in = 8'hFF;
        endcase
    end

    // CPU data-in: ROM is the fallback source
    always_comb begin
        case ({ram_cs, char_cs, in_cs})
            3'b100:  cpu_din = ram_data;
            3'b010:  cpu_din = char_dout;
            3'b001:  cpu_din = cab_in;
            default: cpu_din = rom_data;
        endcase
    end

    // Banked ROM: upper half of the CPU map lands at 8000 + bank*4000
    always_comb begin
        rom_addr[13:0] = A[13:0];
        if (!A[15]) rom_addr[17:14] = {3'b000, A[14]};
        else        rom_addr[17:14] = 4'd2 + {1'b0, bank};
    end

    assign irq_ack = !iorq_n && !m1_n;

    // VBL interrupt: request on falling edge of int_rqb, ack wins ties
    always_ff @(posedge clk or negedge t80_rst_n) begin
        if (!t80_rst_n) begin
            int_rqb <= 1'b1; int_rqb_last <= 1'b1; int_n <= 1'b1;
        end else if (cen6) begin
            int_rqb      <= LVBL && (V[7:5] != 3'd3);
            int_rqb_last <= int_rqb;
            if (irq_ack)                     int_n <= 1'b1;
            else if (int_rqb_last && !int_rqb) int_n <= 1'b0;
        end
    end

    // Wait states: one lost cycle per M1, stall after a new ROM select until rom_ok
    always_ff @(posedge clk or negedge t80_rst_n) begin
        if (!t80_rst_n) begin
            mw0 <= 1'b1; mw1 <= 1'b1; wait_n <= 1'b1; rom_cs_last <= 1'b0;
        end else begin
            mw0         <= mw1 ? m1_n : 1'b1;
            rom_cs_last <= rom_cs;
            if (cen6) mw1 <= mw0;
            if ((char_wait && char_cs) || (rom_cs && !rom_cs_last) || !mw1) wait_n <= 1'b0;
            else if (rom_ok) wait_n <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jt1943_main_glue.sv
// Testbench for jt1943_main_glue: directed steps plus randomized decode and
// register traffic checked against a range/arithmetic reference model.
module tb_jt1943_main_glue;

    logic clk = 1'b0, t80_rst_n, cen6;
    logic [15:0] A;
    logic mreq_n, rfsh_n, rd_n, wr_n, m1_n, iorq_n;
    logic [7:0] cpu_dout, cpu_din;
    logic wait_n, int_n;
    logic [8:0] V;
    logic LVBL;
    logic [7:0] char_dout, ram_dout, rom_data;
    logic char_wait, rom_ok;
    logic [6:0] joystick1, joystick2;
    logic [1:0] start_button, coin_input;
    logic [7:0] dipsw_a, dipsw_b;
    logic cheat_invincible;
    logic rom_cs, ram_cs, char_cs, snd_latch_cs, OKOUT;
    logic [1:0] scr1posh_cs, scr2posh_cs;
    logic [17:0] rom_addr;
    logic [7:0] scrposv;
    logic CHON, SC1ON, SC2ON, OBJON, flip, sres_b, coin_cnt;

    int tests = 0, fails = 0;
    int cen_ph = 0;
    logic [2:0] m_bank = 3'd0;
    logic [7:0] m_prot = 8'd0;

    jt1943_main_glue dut (
        .clk(clk), .t80_rst_n(t80_rst_n), .cen6(cen6), .A(A),
        .mreq_n(mreq_n), .rfsh_n(rfsh_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n), .iorq_n(iorq_n),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .wait_n(wait_n), .int_n(int_n),
        .V(V), .LVBL(LVBL), .char_dout(char_dout), .ram_dout(ram_dout), .rom_data(rom_data),
        .char_wait(char_wait), .rom_ok(rom_ok), .joystick1(joystick1), .joystick2(joystick2),
        .start_button(start_button), .coin_input(coin_input), .dipsw_a(dipsw_a), .dipsw_b(dipsw_b),
        .cheat_invincible(cheat_invincible), .rom_cs(rom_cs), .ram_cs(ram_cs), .char_cs(char_cs),
        .snd_latch_cs(snd_latch_cs), .OKOUT(OKOUT), .scr1posh_cs(scr1posh_cs), .scr2posh_cs(scr2posh_cs),
        .rom_addr(rom_addr), .scrposv(scrposv), .CHON(CHON), .SC1ON(SC1ON), .SC2ON(SC2ON),
        .OBJON(OBJON), .flip(flip), .sres_b(sres_b), .coin_cnt(coin_cnt)
    );

    always #5 clk = ~clk;

    // 6 MHz enable: one clk in four
    initial begin
        cen6 = 1'b0;
        forever begin
            @(negedge clk);
            cen_ph = (cen_ph + 1) % 4;
            cen6 = (cen_ph == 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Protection answers as a lookup over key/value pairs
    function automatic logic [7:0] sec_ref(input logic [7:0] p);
        logic [7:0] keys [6] = '{8'h24, 8'h60, 8'h01, 8'h55, 8'h56, 8'h97};
        logic [7:0] vals [6] = '{8'h1D, 8'hF7, 8'hAC, 8'h50, 8'hE2, 8'h5D};
        for (int i = 0; i < 6; i++) if (p == keys[i]) return vals[i];
        return 8'h00;
    endfunction

    function automatic logic [7:0] cab_ref(input logic [2:0] k);
        case (k)
            3'd0: return {coin_input, 2'b11, ~LVBL, 1'b1, start_button};
            3'd1: return {1'b1, joystick1};
            3'd2: return {1'b1, joystick2};
            3'd3: return dipsw_a;
            3'd4: return dipsw_b;
            3'd7: return sec_ref(m_prot);
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [31:0] rom_ref(input logic [15:0] a);
        if (a < 16'h8000) return {16'd0, a};
        return 32'h8000 + 32'(m_bank) * 32'h4000 + (32'(a) & 32'h3FFF);
    endfunction

    task automatic idle();
        @(negedge clk);
        mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        A = a; cpu_dout = d; mreq_n = 1'b0; wr_n = 1'b0;
        repeat (4) @(negedge clk);
        mreq_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic bus_read(input logic [15:0] a);
        @(negedge clk);
        A = a; mreq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1;
        #1;
    endtask

    task automatic randomize_sources();
        char_dout = 8'($urandom); ram_dout = 8'($urandom); rom_data = 8'($urandom);
        joystick1 = 7'($urandom); joystick2 = 7'($urandom);
        start_button = 2'($urandom); coin_input = 2'($urandom);
        dipsw_a = 8'($urandom); dipsw_b = 8'($urandom);
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0] d, exp_din;
        logic act, seen;
        logic [7:0] keys [8] = '{8'h24, 8'h60, 8'h01, 8'h55, 8'h56, 8'h97, 8'h02, 8'hFF};

        t80_rst_n = 1'b0; A = 16'h0000; mreq_n = 1'b1; rfsh_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        m1_n = 1'b1; iorq_n = 1'b1; cpu_dout = 8'h00; V = 9'd0; LVBL = 1'b1;
        char_wait = 1'b0; rom_ok = 1'b1; cheat_invincible = 1'b0;
        randomize_sources();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sres_b", sres_b, 1);
        chk("rst_ctrl", {CHON, flip, coin_cnt, SC1ON, SC2ON, OBJON}, 0);
        chk("rst_scrposv", scrposv, 0);
        chk("rst_wait_n", wait_n, 1);
        chk("rst_int_n", int_n, 1);
        @(negedge clk);
        t80_rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Bank register, directed then random
        bus_write(16'hC804, 8'hFC); m_bank = 3'd7;
        chk("bank_ctrl", {CHON, flip, sres_b, coin_cnt}, 4'b1100);
        bus_read(16'h8000);
        chk("bank_rom_addr", rom_addr, 32'h24000);
        chk("bank_rom_cs", rom_cs, 1);
        idle();
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            bus_write(16'hC804, d);
            m_bank = d[4:2];
            chk("rbank_ctrl", {CHON, flip, sres_b, coin_cnt}, {d[7], d[6], ~d[5], |d[1:0]});
            a = 16'($urandom) | 16'h8000;
            bus_read(a);
            chk("rbank_rom_addr", rom_addr, rom_ref(a));
            idle();
        end

        // Graphics enables, vertical scroll, scroll H strobes
        bus_write(16'hD806, 8'h70);
        chk("gfxen", {OBJON, SC2ON, SC1ON}, 3'b111);
        bus_write(16'hD802, 8'h33);
        chk("scrposv", scrposv, 8'h33);
        @(negedge clk); A = 16'hD800; mreq_n = 1'b0; wr_n = 1'b0; #1;
        chk("scr1posh_lsb", {scr1posh_cs, scr2posh_cs}, 4'b0100);
        @(negedge clk); A = 16'hD804; #1;
        chk("scr2posh_msb", {scr1posh_cs, scr2posh_cs}, 4'b0010);
        @(negedge clk); A = 16'hD808; #1;
        chk("scrposh_a3", {scr1posh_cs, scr2posh_cs}, 4'b0000);
        @(negedge clk); A = 16'hD800; wr_n = 1'b1; #1;
        chk("scrposh_rd", {scr1posh_cs, scr2posh_cs}, 4'b0000);
        idle();

        // Random decode / data-in / ROM address against the memory map
        for (int i = 0; i < 40; i++) begin
            randomize_sources();
            a = 16'($urandom);
            if (i % 4 == 0) a = 16'hC000 | 16'($urandom_range(0, 7));
            @(negedge clk);
            A = a; rfsh_n = ($urandom_range(0, 3) != 0); mreq_n = 1'b0; rd_n = 1'b0;
            #1;
            act = rfsh_n;
            if (!act || a < 16'hC000) exp_din = rom_data;
            else if (a >= 16'hE000) exp_din = ram_dout;
            else if (a < 16'hC800) exp_din = cab_ref(a[2:0]);
            else if (a >= 16'hD000 && a < 16'hD800) exp_din = char_dout;
            else exp_din = rom_data;
            chk("dec_cs", {rom_cs, ram_cs, char_cs},
                {act && a < 16'hC000, act && a >= 16'hE000, act && a >= 16'hD000 && a < 16'hD800});
            chk("dec_din", cpu_din, exp_din);
            chk("dec_rom_addr", rom_addr, rom_ref(a));
        end
        rfsh_n = 1'b1;
        idle();

        // VBL bit in cabinet word 0
        bus_read(16'hC000); LVBL = 1'b0; #1;
        chk("cab_lvbl", cpu_din, cab_ref(3'd0));
        @(negedge clk); LVBL = 1'b1; #1;
        chk("cab_lvbl_hi", cpu_din, cab_ref(3'd0));
        idle();

        // Protection device
        foreach (keys[i]) begin
            bus_write(16'hC807, keys[i]);
            m_prot = keys[i];
            bus_read(16'hC007);
            chk("sec_out", cpu_din, sec_ref(m_prot));
            idle();
        end

        // Cheat read
        cheat_invincible = 1'b1; ram_dout = 8'h9A;
        bus_read(16'hF206);
`ifdef CHEAT_INVINCIBLE_EN
        chk("cheat_f206", cpu_din, 8'h40);
`else
        chk("cheat_f206", cpu_din, 8'h9A);
`endif
        cheat_invincible = 1'b0; #1;
        chk("cheat_off", cpu_din, 8'h9A);
        idle();

        // Interrupt: clear, raise on V[7:5]=3, acknowledge
        repeat (20) @(negedge clk);
        iorq_n = 1'b0; m1_n = 1'b0;
        repeat (8) @(negedge clk);
        iorq_n = 1'b1; m1_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("int_idle", int_n, 1);
        V = 9'h060;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (!int_n) seen = 1'b1;
        end
        chk("int_fall", seen, 1);
        V = 9'h000;
        repeat (4) @(negedge clk);
        chk("int_held", int_n, 0);
        iorq_n = 1'b0; m1_n = 1'b0;
        repeat (8) @(negedge clk);
        iorq_n = 1'b1; m1_n = 1'b1;
        @(negedge clk);
        chk("int_ack", int_n, 1);

        // M1 wait: a low wait_n must appear during an opcode fetch
        repeat (20) @(negedge clk);
        m1_n = 1'b0; seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!wait_n) seen = 1'b1;
        end
        chk("m1_wait", seen, 1);
        m1_n = 1'b1;
        repeat (16) @(negedge clk);
        chk("m1_release", wait_n, 1);

        // ROM select stall until rom_ok
        rom_ok = 1'b0;
        repeat (3) @(negedge clk);
        A = 16'h1234; mreq_n = 1'b0; rd_n = 1'b0;
        @(negedge clk);
        chk("rom_stall", wait_n, 0);
        repeat (5) @(negedge clk);
        chk("rom_stall_hold", wait_n, 0);
        rom_ok = 1'b1;
        @(negedge clk);
        chk("rom_ok_release", wait_n, 1);

        // Char access stall only while char is selected
        A = 16'hC000; char_wait = 1'b1;
        repeat (2) @(negedge clk);
        chk("char_wait_nosel", wait_n, 1);
        A = 16'hD000;
        @(negedge clk);
        chk("char_wait", wait_n, 0);
        char_wait = 1'b0;
        @(negedge clk);
        chk("char_wait_release", wait_n, 1);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
